// File: rtl/gpio_pad_ctrl_pkg.sv
// Shared definitions for the GPIO pad controller: config word layout, reset value,
// interrupt modes and pad drive-mode encodings.
package gpio_pad_ctrl_pkg;

   localparam int unsigned CFG_WIDTH = 10;

   localparam int unsigned CFG_DM_MSB       = 9;
   localparam int unsigned CFG_DM_LSB       = 7;
   localparam int unsigned CFG_INPUT_DIS    = 6;
   localparam int unsigned CFG_MGMT_EN      = 5;
   localparam int unsigned CFG_OEB_FORCE    = 4;
   localparam int unsigned CFG_IRQ_EN       = 3;
   localparam int unsigned CFG_IRQ_MODE_MSB = 2;
   localparam int unsigned CFG_IRQ_MODE_LSB = 1;
   localparam int unsigned CFG_DEB_EN       = 0;

   localparam logic [CFG_WIDTH-1:0] CFG_RESET = 10'h0A0;

   typedef enum logic [1:0] {
      IRQ_RISE  = 2'b00,
      IRQ_FALL  = 2'b01,
      IRQ_BOTH  = 2'b10,
      IRQ_LEVEL = 2'b11
   } irq_mode_e;

   localparam logic [2:0] DM_ANALOG        = 3'b000;
   localparam logic [2:0] DM_INPUT_NOPULL  = 3'b001;
   localparam logic [2:0] DM_INPUT_PULLDN  = 3'b010;
   localparam logic [2:0] DM_INPUT_PULLUP  = 3'b011;
   localparam logic [2:0] DM_OUT_OD_LOW    = 3'b100;
   localparam logic [2:0] DM_OUT_OD_HIGH   = 3'b101;
   localparam logic [2:0] DM_OUT_STRONG    = 3'b110;
   localparam logic [2:0] DM_OUT_STRONG_HS = 3'b111;

   // Field order matches the bit indices above (first field is the MSB).
   typedef struct packed {
      logic [2:0] dm;
      logic       input_dis;
      logic       mgmt_en;
      logic       oeb_force;
      logic       irq_en;
      irq_mode_e  irq_mode;
      logic       deb_en;
   } cfg_t;

endpackage

// File: rtl/gpio_in_filter.sv
// Pad input conditioning: multi-flop synchroniser followed by an optional
// stable-count debouncer.
module gpio_in_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic deb_en,
   input  logic pad_in,
   output logic filtered
);

   localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic [CNT_W-1:0]       cnt;

   assign sync = sync_q[SYNC_STAGES-1];

   // A new level is accepted only after it has differed from filtered for DEB_CYCLES cycles.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q   <= '0;
         filtered <= 1'b0;
         cnt      <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
         if (!deb_en) begin
            filtered <= sync;
            cnt      <= '0;
         end else if (sync == filtered) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            filtered <= sync;
            cnt      <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Per-pin GPIO controller: serial config chain, pad output muxing, input
// conditioning and sticky edge/level interrupt.
import gpio_pad_ctrl_pkg::*;

module gpio_pad_ctrl #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DEB_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       serial_data_in,
   input  logic       serial_shift,
   input  logic       serial_load,
   output logic       serial_data_out,
   input  logic       mgmt_out,
   input  logic       mgmt_oeb,
   input  logic       user_out,
   input  logic       user_oeb,
   input  logic       irq_clr,
   input  logic       pad_in,
   output logic       pad_out,
   output logic       pad_oen_n,
   output logic       pad_input_dis,
   output logic [2:0] pad_dm,
   output logic       mgmt_in,
   output logic       user_in,
   output logic       irq
);

   logic [CFG_WIDTH-1:0] shreg;
   cfg_t                 cfg;
   logic                 filtered;
   logic                 prev;
   logic                 rise;
   logic                 fall;
   logic                 evt;
   logic                 irq_next;

   gpio_in_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES)
   ) u_in_filter (
      .clk      (clk),
      .resetn   (resetn),
      .deb_en   (cfg.deb_en),
      .pad_in   (pad_in),
      .filtered (filtered)
   );

   // Load captures the pre-shift register, so a coincident shift is not seen by cfg.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         shreg           <= '0;
         serial_data_out <= 1'b0;
         cfg             <= cfg_t'(CFG_RESET);
         prev            <= 1'b0;
         irq             <= 1'b0;
      end else begin
         if (serial_shift) begin
            shreg <= {shreg[CFG_WIDTH-2:0], serial_data_in};
         end
         serial_data_out <= shreg[CFG_WIDTH-1];
         if (serial_load) begin
            cfg <= cfg_t'(shreg);
         end
         prev <= filtered;
         irq  <= irq_next;
      end
   end

   // Event select and interrupt update; a new event outranks irq_clr.
   always_comb begin
      rise     = filtered & ~prev;
      fall     = ~filtered & prev;
      evt      = 1'b0;
      irq_next = irq;
      case (cfg.irq_mode)
         IRQ_RISE:  evt = rise;
         IRQ_FALL:  evt = fall;
         IRQ_BOTH:  evt = rise | fall;
         IRQ_LEVEL: evt = filtered;
         default:   evt = 1'b0;
      endcase
      if (!cfg.irq_en) begin
         irq_next = 1'b0;
      end else if (evt) begin
         irq_next = 1'b1;
      end else if (irq_clr) begin
         irq_next = 1'b0;
      end
   end

   assign pad_out       = cfg.mgmt_en ? mgmt_out : user_out;
   assign pad_oen_n     = cfg.oeb_force | (cfg.mgmt_en ? mgmt_oeb : user_oeb);
   assign pad_dm        = cfg.dm;
   assign pad_input_dis = cfg.input_dis;
   assign mgmt_in       = filtered & ~cfg.input_dis;
   assign user_in       = filtered & ~cfg.input_dis;

endmodule
